// File: rtl/alu_issue_ctrl_pkg.sv
// Shared definitions for the ALU issue controller: widths, instruction field
// layout, opcodes, ALU select codes and the control FSM states.
package alu_issue_ctrl_pkg;

  localparam int unsigned DATA_W  = 18;
  localparam int unsigned INSTR_W = 18;
  localparam int unsigned NREGS   = 8;
  localparam int unsigned REG_AW  = 3;

  localparam int unsigned OP_LSB  = 15;
  localparam int unsigned RD_LSB  = 12;
  localparam int unsigned RS1_LSB = 9;
  localparam int unsigned RS2_LSB = 6;
  localparam int unsigned IMM_LSB = 0;
  localparam int unsigned OP_W    = 3;
  localparam int unsigned IMM_W   = 9;

  typedef enum logic [2:0] {
    OP_AND  = 3'b000,
    OP_ADD  = 3'b001,
    OP_OR   = 3'b010,
    OP_XOR  = 3'b011,
    OP_LDI  = 3'b100,
    OP_HALT = 3'b101,
    OP_ILL6 = 3'b110,
    OP_ILL7 = 3'b111
  } opcode_t;

  typedef enum logic [1:0] {
    ALU_AND = 2'b00,
    ALU_ADD = 2'b01,
    ALU_OR  = 2'b10,
    ALU_XOR = 2'b11
  } alu_sel_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EXEC,
    ST_WB,
    ST_HALT
  } state_t;

  // ALU opcodes share the low two bits with the ALU select encoding.
  function automatic logic op_is_alu(input logic [2:0] op);
    return op[2] == 1'b0;
  endfunction

  function automatic logic op_is_illegal(input logic [2:0] op);
    return op[2:1] == 2'b11;
  endfunction

endpackage

// File: rtl/regfile8x18.sv
// Register file: two combinational operand reads, one debug read and one
// synchronous write port. Entry 0 is hard-wired to zero.
module regfile8x18 #(
  parameter int unsigned DATA_W = 18,
  parameter int unsigned NREGS  = 8,
  parameter int unsigned AW     = $clog2(NREGS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [AW-1:0]     raddr_a,
  output logic [DATA_W-1:0] rdata_a,
  input  logic [AW-1:0]     raddr_b,
  output logic [DATA_W-1:0] rdata_b,
  input  logic [AW-1:0]     dbg_addr,
  output logic [DATA_W-1:0] dbg_data
);

  logic [DATA_W-1:0] mem [NREGS];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < NREGS; i++) begin
        mem[i] <= '0;
      end
    end else if (we && (waddr != '0)) begin
      mem[waddr] <= wdata;
    end
  end

  always_comb begin
    rdata_a  = (raddr_a  == '0) ? '0 : mem[raddr_a];
    rdata_b  = (raddr_b  == '0) ? '0 : mem[raddr_b];
    dbg_data = (dbg_addr == '0) ? '0 : mem[dbg_addr];
  end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Single-issue controller driving an external ALU: decode, operand fetch,
// result capture and write-back, one instruction every three cycles.
module alu_issue_ctrl #(
  parameter int unsigned DATA_W = 18,
  parameter int unsigned NREGS  = 8,
  parameter int unsigned AW     = $clog2(NREGS)
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  instr_valid,
  output logic                                  instr_ready,
  input  logic [alu_issue_ctrl_pkg::INSTR_W-1:0] instr,
  output logic [DATA_W-1:0]                     alu_a,
  output logic [DATA_W-1:0]                     alu_b,
  output logic [1:0]                            alu_sel,
  input  logic [DATA_W-1:0]                     alu_res,
  input  logic                                  alu_cout,
  output logic                                  carry_flag,
  output logic                                  done,
  output logic                                  illegal,
  output logic                                  halted,
  input  logic [AW-1:0]                         dbg_addr,
  output logic [DATA_W-1:0]                     dbg_data
);

  import alu_issue_ctrl_pkg::*;

  state_t state, state_nxt;

  opcode_t           op_q;
  logic [AW-1:0]     rd_q;
  logic [IMM_W-1:0]  imm_q;
  logic [DATA_W-1:0] res_q;

  logic [OP_W-1:0]   f_op;
  logic [AW-1:0]     f_rd, f_rs1, f_rs2;
  logic [IMM_W-1:0]  f_imm;
  logic [DATA_W-1:0] rs1_data, rs2_data;
  logic              xfer;
  logic              rf_we;

  assign f_op  = instr[OP_LSB  +: OP_W];
  assign f_rd  = instr[RD_LSB  +: AW];
  assign f_rs1 = instr[RS1_LSB +: AW];
  assign f_rs2 = instr[RS2_LSB +: AW];
  assign f_imm = instr[IMM_LSB +: IMM_W];

  assign instr_ready = (state == ST_IDLE) && !rst;
  assign xfer        = instr_valid && instr_ready;
  assign rf_we       = (state == ST_WB) && (op_is_alu(op_q) || (op_q == OP_LDI));

  regfile8x18 #(
    .DATA_W (DATA_W),
    .NREGS  (NREGS),
    .AW     (AW)
  ) u_regfile (
    .clk      (clk),
    .rst      (rst),
    .we       (rf_we),
    .waddr    (rd_q),
    .wdata    (res_q),
    .raddr_a  (f_rs1),
    .rdata_a  (rs1_data),
    .raddr_b  (f_rs2),
    .rdata_b  (rs2_data),
    .dbg_addr (dbg_addr),
    .dbg_data (dbg_data)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE: if (xfer) state_nxt = ST_EXEC;
      ST_EXEC: state_nxt = ST_WB;
      ST_WB:   state_nxt = (op_q == OP_HALT) ? ST_HALT : ST_IDLE;
      ST_HALT: state_nxt = ST_HALT;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q       <= OP_AND;
      rd_q       <= '0;
      imm_q      <= '0;
      res_q      <= '0;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_sel    <= '0;
      carry_flag <= 1'b0;
      done       <= 1'b0;
      illegal    <= 1'b0;
      halted     <= 1'b0;
    end else begin
      done    <= 1'b0;
      illegal <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (xfer) begin
            op_q  <= opcode_t'(f_op);
            rd_q  <= f_rd;
            imm_q <= f_imm;
            // Non-ALU opcodes leave the operand registers untouched.
            if (op_is_alu(f_op)) begin
              alu_a   <= rs1_data;
              alu_b   <= rs2_data;
              alu_sel <= f_op[1:0];
            end
          end
        end
        ST_EXEC: begin
          if (op_is_alu(op_q)) begin
            res_q      <= alu_res;
            carry_flag <= alu_cout;
          end else if (op_q == OP_LDI) begin
            res_q <= DATA_W'(imm_q);
          end
        end
        ST_WB: begin
          done    <= 1'b1;
          illegal <= op_is_illegal(op_q);
          if (op_q == OP_HALT) halted <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl with a behavioural external ALU.
module tb_alu_issue_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        instr_valid;
  logic        instr_ready;
  logic [17:0] instr;
  logic [17:0] alu_a, alu_b, alu_res;
  logic [1:0]  alu_sel;
  logic        alu_cout;
  logic        carry_flag, done, illegal, halted;
  logic [2:0]  dbg_addr;
  logic [17:0] dbg_data;

  int passes = 0;
  int checks = 0;

  int          last_lat;
  logic        last_ill;
  logic [17:0] last_wb_dbg;
  logic        last_rdy_exec;
  logic [1:0]  last_sel_exec;
  int          done_cnt;

  always #5 clk = ~clk;

  alu_issue_ctrl #(.DATA_W(18), .NREGS(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instr       (instr),
    .alu_a       (alu_a),
    .alu_b       (alu_b),
    .alu_sel     (alu_sel),
    .alu_res     (alu_res),
    .alu_cout    (alu_cout),
    .carry_flag  (carry_flag),
    .done        (done),
    .illegal     (illegal),
    .halted      (halted),
    .dbg_addr    (dbg_addr),
    .dbg_data    (dbg_data)
  );

  // External ALU environment model.
  always_comb begin
    alu_cout = 1'b0;
    alu_res  = '0;
    case (alu_sel)
      2'b00: alu_res = alu_a & alu_b;
      2'b01: {alu_cout, alu_res} = {1'b0, alu_a} + {1'b0, alu_b};
      2'b10: alu_res = alu_a | alu_b;
      default: alu_res = alu_a ^ alu_b;
    endcase
  end

  function automatic logic [17:0] ldi(input logic [2:0] rd, input logic [8:0] imm);
    return {3'b100, rd, 3'b000, imm};
  endfunction

  function automatic logic [17:0] rop(input logic [2:0] op, input logic [2:0] rd,
                                      input logic [2:0] rs1, input logic [2:0] rs2);
    return {op, rd, rs1, rs2, 6'b0};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  task automatic check_reg(input string tag, input logic [2:0] r, input logic [17:0] exp);
    dbg_addr = r;
    #1;
    check(tag, 32'(dbg_data), 32'(exp));
  endtask

  // Offers one instruction, then measures edges from transfer to done.
  task automatic send(input logic [17:0] w);
    int waitc = 0;
    last_lat = -1;
    last_ill = 1'b0;
    last_wb_dbg = '0;
    last_rdy_exec = 1'b1;
    last_sel_exec = '0;
    @(negedge clk);
    while (!instr_ready && waitc < 20) begin
      @(negedge clk);
      waitc++;
    end
    if (!instr_ready) return;
    instr = w;
    instr_valid = 1'b1;
    @(posedge clk);
    #1;
    instr_valid = 1'b0;
    instr = 18'h3FFFF;
    last_rdy_exec = instr_ready;
    last_sel_exec = alu_sel;
    for (int i = 1; i <= 6; i++) begin
      @(posedge clk);
      #1;
      if (i == 1) last_wb_dbg = dbg_data;
      if (done) begin
        last_lat = i;
        last_ill = illegal;
        break;
      end
    end
  endtask

  task automatic issue(input string tag, input logic [17:0] w, input logic exp_ill);
    send(w);
    check({tag, "_lat"}, 32'(last_lat), 32'd2);
    check({tag, "_ill"}, 32'(last_ill), 32'(exp_ill));
  endtask

  initial begin
    rst = 1'b1;
    instr_valid = 1'b0;
    instr = '0;
    dbg_addr = '0;
    repeat (2) @(negedge clk);
    check("rst_ready", 32'(instr_ready), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_halted", 32'(halted), 32'd0);
    check("rst_carry", 32'(carry_flag), 32'd0);
    check("rst_alu_a", 32'(alu_a), 32'd0);
    check("rst_alu_sel", 32'(alu_sel), 32'd0);
    rst = 1'b0;
    #1;
    check("idle_ready", 32'(instr_ready), 32'd1);
    for (int r = 0; r < 8; r++) check_reg("rst_reg", 3'(r), 18'h0);

    // LDI / LDI / ADD
    issue("ldi_r1", ldi(3'd1, 9'h1FF), 1'b0);
    check("exec_not_ready", 32'(last_rdy_exec), 32'd0);
    check_reg("r1_1ff", 3'd1, 18'h001FF);
    issue("ldi_r2", ldi(3'd2, 9'h001), 1'b0);
    issue("add_r3", rop(3'b001, 3'd3, 3'd1, 3'd2), 1'b0);
    check("add_sel", 32'(last_sel_exec), 32'd1);
    check("add_a", 32'(alu_a), 32'h1FF);
    check("add_b", 32'(alu_b), 32'h001);
    check_reg("r3_200", 3'd3, 18'h00200);
    check("add_carry0", 32'(carry_flag), 32'd0);

    // AND / OR / XOR
    issue("ldi_r1b", ldi(3'd1, 9'h0F0), 1'b0);
    issue("ldi_r2b", ldi(3'd2, 9'h0FF), 1'b0);
    issue("and_r4", rop(3'b000, 3'd4, 3'd1, 3'd2), 1'b0);
    check("and_sel", 32'(last_sel_exec), 32'd0);
    issue("or_r5", rop(3'b010, 3'd5, 3'd1, 3'd2), 1'b0);
    check("or_sel", 32'(last_sel_exec), 32'd2);
    issue("xor_r6", rop(3'b011, 3'd6, 3'd1, 3'd2), 1'b0);
    check("xor_sel", 32'(last_sel_exec), 32'd3);
    check_reg("r4_and", 3'd4, 18'h000F0);
    check_reg("r5_or", 3'd5, 18'h000FF);
    check_reg("r6_xor", 3'd6, 18'h0000F);

    // rd == rs1 == rs2 doubling up to the carry-out
    for (int k = 0; k < 8; k++) issue("dbl", rop(3'b001, 3'd3, 3'd3, 3'd3), 1'b0);
    check_reg("r3_20000", 3'd3, 18'h20000);
    check("dbl_carry0", 32'(carry_flag), 32'd0);
    issue("dbl_ovf", rop(3'b001, 3'd3, 3'd3, 3'd3), 1'b0);
    check_reg("r3_wrap", 3'd3, 18'h00000);
    check("ovf_carry1", 32'(carry_flag), 32'd1);

    // LDI keeps carry and operand registers
    issue("ldi_r7", ldi(3'd7, 9'h0AB), 1'b0);
    check("ldi_keep_carry", 32'(carry_flag), 32'd1);
    check("ldi_keep_a", 32'(alu_a), 32'h20000);
    check("ldi_keep_sel", 32'(alu_sel), 32'd1);
    check_reg("r7_ab", 3'd7, 18'h000AB);

    // Illegal opcode
    issue("illegal7", {3'b111, 3'd1, 3'd2, 3'd2, 6'b0}, 1'b1);
    check("ill_carry", 32'(carry_flag), 32'd1);
    @(posedge clk);
    #1;
    check("ill_done_1cyc", 32'(done), 32'd0);
    check_reg("ill_r1", 3'd1, 18'h000F0);

    // Debug read during the write-back cycle returns the old value
    dbg_addr = 3'd4;
    issue("ldi_r4", ldi(3'd4, 9'h123), 1'b0);
    check("wb_dbg_old", 32'(last_wb_dbg), 32'h000F0);
    check_reg("r4_new", 3'd4, 18'h00123);

    // R0 writes discarded
    issue("ldi_r0", ldi(3'd0, 9'h155), 1'b0);
    check_reg("r0_zero", 3'd0, 18'h0);
    issue("add_r7_r0", rop(3'b001, 3'd7, 3'd0, 3'd0), 1'b0);
    check_reg("r7_zero", 3'd7, 18'h0);
    check("r0_add_carry", 32'(carry_flag), 32'd0);

    // Reset in EXEC aborts the instruction
    @(negedge clk);
    instr = ldi(3'd5, 9'h0AA);
    instr_valid = 1'b1;
    @(posedge clk);
    #1;
    instr_valid = 1'b0;
    check("abort_in_exec", 32'(instr_ready), 32'd0);
    rst = 1'b1;
    #1;
    check("abort_rst_ready", 32'(instr_ready), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    done_cnt = 0;
    repeat (4) begin
      @(posedge clk);
      #1;
      if (done) done_cnt++;
    end
    check("abort_no_done", 32'(done_cnt), 32'd0);
    check_reg("abort_r5", 3'd5, 18'h0);
    check_reg("abort_r4", 3'd4, 18'h0);
    issue("post_abort_ldi", ldi(3'd5, 9'h0AA), 1'b0);
    check_reg("r5_aa", 3'd5, 18'h000AA);
    issue("ldi_r1c", ldi(3'd1, 9'h1C3), 1'b0);

    // HALT
    issue("halt", {3'b101, 15'h0}, 1'b0);
    check("halted_set", 32'(halted), 32'd1);
    check("halt_not_ready", 32'(instr_ready), 32'd0);
    @(negedge clk);
    instr = ldi(3'd1, 9'h055);
    instr_valid = 1'b1;
    done_cnt = 0;
    repeat (8) begin
      @(posedge clk);
      #1;
      if (done) done_cnt++;
    end
    instr_valid = 1'b0;
    check("halt_no_done", 32'(done_cnt), 32'd0);
    check("halt_still", 32'(halted), 32'd1);
    check("halt_ready0", 32'(instr_ready), 32'd0);
    check_reg("halt_r1", 3'd1, 18'h001C3);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("unhalt", 32'(halted), 32'd0);
    check("unhalt_ready", 32'(instr_ready), 32'd1);
    for (int r = 0; r < 8; r++) check_reg("halt_rst_reg", 3'(r), 18'h0);
    issue("final_ldi", ldi(3'd6, 9'h03C), 1'b0);
    check_reg("r6_3c", 3'd6, 18'h0003C);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
